// File: rtl/ssc_pkg.sv
// Shared types and mux-select encodings for the selection-sort controller.
package ssc_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INIT_MIN  = 3'd1,
      COMPARE   = 3'd2,
      READ_TEMP = 3'd3,
      WRITE_I   = 3'd4,
      WRITE_MIN = 3'd5,
      DONE      = 3'd6
   } state_t;

   localparam logic [1:0] AMUX_CNT1 = 2'd0;
   localparam logic [1:0] AMUX_CNT2 = 2'd1;
   localparam logic [1:0] AMUX_MIN  = 2'd2;

   localparam logic DMUX_MIN  = 1'b0;
   localparam logic DMUX_TEMP = 1'b1;

   localparam logic SMUX_CNT1 = 1'b0;
   localparam logic SMUX_CNT2 = 1'b1;

endpackage

// File: rtl/ssc_counter.sv
// 8-bit index counter with synchronous load and increment enable.
module ssc_counter
   import ssc_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst_N,
   input  logic       Load,
   input  logic [7:0] Load_Val,
   input  logic       Inc,
   output logic [7:0] Count
);

   logic [7:0] cnt_q, cnt_d;

   // Load wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (Load) begin
         cnt_d = Load_Val;
      end else if (Inc) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign Count = cnt_q;

endmodule

// File: rtl/ssc_controller.sv
// Selection-sort sequencer: drives indices, mux selects, loads and write strobe.
// Optional cycle counter output Sort_Cycles enabled by `define SSC_PERF_CNT_EN.
module ssc_controller
   import ssc_pkg::*;
#(
   parameter int MEM_DEPTH = 256
) (
   input  logic        Clk,
   input  logic        Rst_N,
   input  logic        Start,
   output logic        Busy,
   output logic        Done,
   output logic        Mem_Write,
   output logic [7:0]  Cnt1_Out,
   output logic [7:0]  Cnt2_Out,
   output logic [1:0]  Sel_AMux,
   output logic        Sel_DMux,
   output logic        Sel_Mux,
   output logic        Load_Min,
`ifdef SSC_PERF_CNT_EN
   output logic [15:0] Sort_Cycles,
`endif
   output logic        Load_Temp
);

   localparam logic [7:0] LAST_J = 8'(MEM_DEPTH - 1);
   localparam logic [7:0] LAST_I = 8'(MEM_DEPTH - 2);

   state_t     state_q, state_d;
   logic       cnt1_load, cnt1_inc, cnt2_load, cnt2_inc;
   logic [7:0] cnt1_val, cnt2_val;
   logic       start_acc;

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      Busy      = 1'b0;
      Done      = 1'b0;
      Mem_Write = 1'b0;
      Sel_AMux  = AMUX_CNT1;
      Sel_DMux  = DMUX_MIN;
      Sel_Mux   = SMUX_CNT1;
      Load_Min  = 1'b0;
      Load_Temp = 1'b0;
      cnt1_load = 1'b0;
      cnt1_val  = 8'd0;
      cnt1_inc  = 1'b0;
      cnt2_load = 1'b0;
      cnt2_val  = 8'd0;
      cnt2_inc  = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               start_acc = 1'b1;
               cnt1_load = 1'b1;
               cnt1_val  = 8'd0;
               cnt2_load = 1'b1;
               cnt2_val  = 8'd1;
               state_d   = INIT_MIN;
            end
         end
         INIT_MIN: begin
            Busy     = 1'b1;
            Load_Min = 1'b1;
            state_d  = COMPARE;
         end
         COMPARE: begin
            // j stops at the last address so it never wraps, even at depth 256
            Busy     = 1'b1;
            Sel_AMux = AMUX_CNT2;
            Sel_Mux  = SMUX_CNT2;
            if (Cnt2_Out == LAST_J) begin
               state_d = READ_TEMP;
            end else begin
               cnt2_inc = 1'b1;
            end
         end
         READ_TEMP: begin
            Busy      = 1'b1;
            Load_Temp = 1'b1;
            state_d   = WRITE_I;
         end
         WRITE_I: begin
            Busy      = 1'b1;
            Mem_Write = 1'b1;
            state_d   = WRITE_MIN;
         end
         WRITE_MIN: begin
            Busy      = 1'b1;
            Sel_AMux  = AMUX_MIN;
            Sel_DMux  = DMUX_TEMP;
            Mem_Write = 1'b1;
            if (Cnt1_Out == LAST_I) begin
               state_d = DONE;
            end else begin
               cnt1_inc  = 1'b1;
               cnt2_load = 1'b1;
               cnt2_val  = Cnt1_Out + 8'd2;
               state_d   = INIT_MIN;
            end
         end
         DONE: begin
            Done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   ssc_counter u_cnt1 (
      .Clk      (Clk),
      .Rst_N    (Rst_N),
      .Load     (cnt1_load),
      .Load_Val (cnt1_val),
      .Inc      (cnt1_inc),
      .Count    (Cnt1_Out)
   );

   ssc_counter u_cnt2 (
      .Clk      (Clk),
      .Rst_N    (Rst_N),
      .Load     (cnt2_load),
      .Load_Val (cnt2_val),
      .Inc      (cnt2_inc),
      .Count    (Cnt2_Out)
   );

`ifdef SSC_PERF_CNT_EN
   logic [15:0] sort_cycles_q, sort_cycles_d;

   // Cleared on Start accept, counts Busy cycles, saturates, holds after Done
   always_comb begin
      sort_cycles_d = sort_cycles_q;
      if (start_acc) begin
         sort_cycles_d = 16'd0;
      end else if (Busy && (sort_cycles_q != 16'hFFFF)) begin
         sort_cycles_d = sort_cycles_q + 16'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         sort_cycles_q <= 16'd0;
      end else begin
         sort_cycles_q <= sort_cycles_d;
      end
   end

   assign Sort_Cycles = sort_cycles_q;
`endif

endmodule

// File: tb/tb_ssc_controller.sv
// Bench for ssc_controller: behavioural datapath/memory plus a sorted-queue reference.
module tb_ssc_controller;

`ifdef SSC_PERF_CNT_EN
   localparam int N = 8;
`else
   localparam int N = 4;
`endif
   localparam int EXP_BUSY = 4 * (N - 1) + N * (N - 1) / 2;
   localparam int BUDGET   = 4 * EXP_BUSY + 20;

   logic        Clk = 1'b0;
   logic        Rst_N = 1'b0;
   logic        Start = 1'b0;
   logic        Busy, Done, Mem_Write, Sel_DMux, Sel_Mux, Load_Min, Load_Temp;
   logic [7:0]  Cnt1_Out, Cnt2_Out;
   logic [1:0]  Sel_AMux;
`ifdef SSC_PERF_CNT_EN
   logic [15:0] Sort_Cycles;
   logic [15:0] perf_at_accept = 16'd0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   ssc_controller #(.MEM_DEPTH(N)) dut (
      .Clk       (Clk),
      .Rst_N     (Rst_N),
      .Start     (Start),
      .Busy      (Busy),
      .Done      (Done),
      .Mem_Write (Mem_Write),
      .Cnt1_Out  (Cnt1_Out),
      .Cnt2_Out  (Cnt2_Out),
      .Sel_AMux  (Sel_AMux),
      .Sel_DMux  (Sel_DMux),
      .Sel_Mux   (Sel_Mux),
      .Load_Min  (Load_Min),
`ifdef SSC_PERF_CNT_EN
      .Sort_Cycles (Sort_Cycles),
`endif
      .Load_Temp (Load_Temp)
   );

   // Datapath and memory environment driven by the controller outputs
   logic [15:0] mem     [256];
   logic [15:0] pl_data [256];
   bit          pl_en = 1'b0;
   logic [15:0] dp_min = 16'd0;
   logic [15:0] dp_temp = 16'd0;
   logic [7:0]  dp_min_addr = 8'd0;
   logic [7:0]  addr;
   logic [15:0] rd;

   always_comb begin
      addr = (Sel_AMux == 2'd0) ? Cnt1_Out : (Sel_AMux == 2'd1) ? Cnt2_Out : dp_min_addr;
      rd   = mem[addr];
   end

   always @(posedge Clk) begin
      if (pl_en) mem <= pl_data;
      else if (Mem_Write) mem[addr] <= Sel_DMux ? dp_temp : dp_min;
      if (Load_Min || (Busy && rd < dp_min)) begin
         dp_min      <= rd;
         dp_min_addr <= Sel_Mux ? Cnt2_Out : Cnt1_Out;
      end
      if (Load_Temp) dp_temp <= rd;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load_mem();
      pl_en = 1'b1;
      @(posedge Clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic run_sort(input bit hold, output int busy_n, output int done_n,
                           output int wr_n, output logic [7:0] first_min, output bit timed_out);
      bit seen_done = 1'b0;
      bit first = 1'b1;
      busy_n = 0; done_n = 0; wr_n = 0; first_min = 8'hFF;
      Start = 1'b1;
      for (int c = 0; c < BUDGET && !seen_done; c++) begin
         @(posedge Clk); #1;
         if (!hold) Start = 1'b0;
`ifdef SSC_PERF_CNT_EN
         if (c == 0) perf_at_accept = Sort_Cycles;
`endif
         if (Busy) busy_n++;
         if (Mem_Write) wr_n++;
         if (Load_Temp && first) begin
            first_min = dp_min_addr;
            first = 1'b0;
         end
         if (Done) begin
            done_n++;
            seen_done = 1'b1;
         end
      end
      timed_out = !seen_done;
      @(posedge Clk); #1;
      if (Done) done_n++;
   endtask

   task automatic sort_and_verify(input string name, input bit hold);
      logic [15:0] ref_q[$];
      logic [15:0] mn;
      int          exp_first, busy_n, done_n, wr_n, bad;
      logic [7:0]  first_min;
      bit          to;
      mn = mem[0];
      exp_first = 0;
      for (int k = 1; k < N; k++) if (mem[k] < mn) begin mn = mem[k]; exp_first = k; end
      for (int k = 0; k < N; k++) ref_q.push_back(mem[k]);
      ref_q.sort();
      run_sort(hold, busy_n, done_n, wr_n, first_min, to);
      checks++;
      if (to) begin errors++; $display("FAIL %s done_timeout: no Done within %0d cycles", name, BUDGET); end
      checks++;
      if (busy_n != EXP_BUSY) begin errors++; $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_n, EXP_BUSY); end
      checks++;
      if (done_n != 1) begin errors++; $display("FAIL %s done_pulses: got %0d, expected 1", name, done_n); end
      checks++;
      if (wr_n != 2 * (N - 1)) begin errors++; $display("FAIL %s write_cycles: got %0d, expected %0d", name, wr_n, 2 * (N - 1)); end
      checks++;
      if (first_min !== 8'(exp_first)) begin errors++; $display("FAIL %s first_min_addr: got %0d, expected %0d", name, first_min, exp_first); end
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL %s idle_after_done: Busy got %b, expected 0", name, Busy); end
      bad = -1;
      for (int k = 0; k < N; k++) if (bad < 0 && mem[k] !== ref_q[k]) bad = k;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL %s sorted_word[%0d]: got %0d, expected %0d", name, bad, mem[bad], ref_q[bad]); end
   endtask

   task automatic test_reset();
      Rst_N = 1'b0;
      Start = 1'b0;
      #3;
      checks++;
      if ({Busy, Done, Mem_Write, Cnt1_Out, Cnt2_Out, Sel_AMux, Sel_DMux, Sel_Mux, Load_Min, Load_Temp} !== 25'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b wr=%b i=%0d j=%0d, expected all 0", Busy, Done, Mem_Write, Cnt1_Out, Cnt2_Out);
      end
      @(posedge Clk); #1;
      Rst_N = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", Busy, Done); end
   endtask

   task automatic test_directed();
      for (int k = 0; k < N; k++) pl_data[k] = 16'(N - 1 - k);
      if (N == 4) begin pl_data[1] = 16'd1; pl_data[2] = 16'd2; end
      load_mem();
      sort_and_verify("reverse", 1'b0);
      for (int k = 0; k < N; k++) pl_data[k] = 16'((k % 4 < 2) ? 2 + 2 * (k / 4) : 1 + 2 * (k / 4));
      load_mem();
      sort_and_verify("ties", 1'b0);
      for (int k = 0; k < N; k++) pl_data[k] = 16'(5 + k);
      load_mem();
      sort_and_verify("presorted", 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < N; k++)
            pl_data[k] = (t < 5) ? 16'($urandom()) : 16'($urandom_range(0, 3));
         load_mem();
         sort_and_verify($sformatf("random%0d", t), 1'b0);
      end
   endtask

   task automatic test_reset_mid_sort();
      int nb = 0;
      for (int k = 0; k < N; k++) pl_data[k] = 16'($urandom_range(0, 1000));
      load_mem();
      Start = 1'b1;
      for (int c = 0; c < BUDGET && nb < 7; c++) begin
         @(posedge Clk); #1;
         Start = 1'b0;
         if (Busy) nb++;
      end
      checks++;
      if (nb != 7) begin errors++; $display("FAIL midreset_reach: got %0d busy cycles, expected 7", nb); end
      #2 Rst_N = 1'b0;
      #1;
      checks++;
      if ({Busy, Done, Mem_Write, Cnt1_Out, Cnt2_Out, Sel_AMux, Sel_DMux, Sel_Mux, Load_Min, Load_Temp} !== 25'd0) begin
         errors++;
         $display("FAIL midreset_async: got busy=%b wr=%b i=%0d j=%0d amux=%0d, expected all 0", Busy, Mem_Write, Cnt1_Out, Cnt2_Out, Sel_AMux);
      end
      @(posedge Clk); #1;
      Rst_N = 1'b1;
      @(posedge Clk); #1;
      sort_and_verify("after_reset", 1'b0);
   endtask

   task automatic test_start_held();
      for (int k = 0; k < N; k++) pl_data[k] = 16'($urandom());
      load_mem();
      sort_and_verify("held_first", 1'b1);
      sort_and_verify("held_second", 1'b1);
      Start = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL held_release: Busy got %b, expected 0", Busy); end
   endtask

`ifdef SSC_PERF_CNT_EN
   task automatic test_perf_counter();
      for (int k = 0; k < N; k++) pl_data[k] = 16'(N - 1 - k);
      load_mem();
      sort_and_verify("perf_reverse", 1'b0);
      checks++;
      if (Sort_Cycles !== 16'(EXP_BUSY)) begin errors++; $display("FAIL perf_count: got %0d, expected %0d", Sort_Cycles, EXP_BUSY); end
      repeat (3) begin @(posedge Clk); #1; end
      checks++;
      if (Sort_Cycles !== 16'(EXP_BUSY)) begin errors++; $display("FAIL perf_hold: got %0d, expected %0d", Sort_Cycles, EXP_BUSY); end
      for (int k = 0; k < N; k++) pl_data[k] = 16'($urandom());
      load_mem();
      sort_and_verify("perf_second", 1'b0);
      checks++;
      if (perf_at_accept !== 16'd0) begin errors++; $display("FAIL perf_clear: got %0d, expected 0", perf_at_accept); end
      checks++;
      if (Sort_Cycles !== 16'(EXP_BUSY)) begin errors++; $display("FAIL perf_recount: got %0d, expected %0d", Sort_Cycles, EXP_BUSY); end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid_sort();
      test_start_held();
`ifdef SSC_PERF_CNT_EN
      test_perf_counter();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssc_controller.md
Name: ssc_controller

Overview:
- FSM and counter block that sequences the selection-sort datapath. It drives outer index i (Cnt1_Out), inner index j (Cnt2_Out), the mux selects, the register loads and the memory write strobe.
- It sorts MEM_DEPTH unsigned 16-bit words in place, ascending, in a combinational-read / synchronous-write data memory.
- Sits directly upstream of the datapath. The datapath's internal compare (Read_Data < min) auto-loads min value and address; this controller only forces loads and steers addresses.

Parameters:
- MEM_DEPTH, 256: number of words sorted, legal range 2..256. Addresses are 0..MEM_DEPTH-1.

Ports:
- Clk  in  1  system clock, rising edge
- Rst_N  in  1  asynchronous active-low reset
- Start  in  1  sort request, sampled in IDLE only
- Busy  out  1  high while a sort is in progress
- Done  out  1  one-cycle pulse when the sort completes
- Mem_Write  out  1  data memory write enable; write occurs at the next Clk edge
- Cnt1_Out  out  8  outer index i
- Cnt2_Out  out  8  inner index j
- Sel_AMux  out  2  address select: 0=Cnt1, 1=Cnt2, 2=Min_Addr, 3 unused
- Sel_DMux  out  1  write-data select: 0=Min_Reg, 1=Temp_Reg
- Sel_Mux  out  1  min-address source: 0=Cnt1, 1=Cnt2
- Load_Min  out  1  forced load of min value/address
- Load_Temp  out  1  load temp register from Read_Data

Behaviour:
- Reset (Rst_N low, asynchronous): state=IDLE; Cnt1_Out=Cnt2_Out=0; all other outputs 0. Reset mid-sort aborts immediately. Memory is left partially sorted and is not restored.
- All outputs are Moore, decoded from state. Counters are registered.
- Defaults in every state: Sel_AMux=0, Sel_DMux=0, Sel_Mux=0, Load_Min=0, Load_Temp=0, Mem_Write=0.
- States and transitions:
  - IDLE: Busy=0. Start=1 -> INIT_MIN, with i<=0, j<=1.
  - INIT_MIN: Sel_AMux=0, Sel_Mux=0, Load_Min=1 (min<=mem[i], min_addr<=i). -> COMPARE.
  - COMPARE: Sel_AMux=1, Sel_Mux=1. The datapath self-loads when mem[j] < min. If j==MEM_DEPTH-1 -> READ_TEMP; else j<=j+1 and stay.
  - READ_TEMP: Sel_AMux=0, Load_Temp=1 (temp<=mem[i]). -> WRITE_I.
  - WRITE_I: Sel_AMux=0, Sel_DMux=0, Mem_Write=1 (mem[i]<=min). -> WRITE_MIN.
  - WRITE_MIN: Sel_AMux=2, Sel_DMux=1, Mem_Write=1 (mem[min_addr]<=temp).
    - If i==MEM_DEPTH-2 -> DONE.
    - Else i<=i+1, j<=i+2 -> INIT_MIN.
  - DONE: Done=1 for one cycle, Busy=0. Counters hold. -> IDLE.
- Busy=1 in INIT_MIN, COMPARE, READ_TEMP, WRITE_I and WRITE_MIN.
- Latency: Busy is high for exactly 4*(MEM_DEPTH-1) + MEM_DEPTH*(MEM_DEPTH-1)/2 cycles, followed by one Done cycle.
  - MEM_DEPTH=4: 18 cycles.
  - MEM_DEPTH=8: 56 cycles.
- The swap always executes. When min_addr==i, both writes target the same word and the second write restores the original value.
- Start while Busy or in DONE is ignored and not queued.
- Comparison is strict (<), so on ties the earliest occurrence is selected.
- Counters never exceed MEM_DEPTH-1 and never wrap. When MEM_DEPTH=256, j reaches 255 and is not incremented past it.
- MEM_DEPTH=2: a single outer pass with one COMPARE cycle; Busy lasts 5 cycles.

Optional Feature:
- Macro SSC_PERF_CNT_EN.
- Defined: adds output Sort_Cycles [15:0]. It resets to 0 and clears to 0 on the Start-accept edge. It increments once per Busy cycle, saturates at 16'hFFFF, and holds its value after Done until the next Start.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ssc_pkg holds:
  - the state enum (IDLE, INIT_MIN, COMPARE, READ_TEMP, WRITE_I, WRITE_MIN, DONE)
  - AMUX_CNT1/AMUX_CNT2/AMUX_MIN constants
  - DMUX_MIN/DMUX_TEMP constants
  - SMUX_CNT1/SMUX_CNT2 constants
- One sub-module, ssc_counter: an 8-bit up-counter with sync load, load value and increment enable, plus async active-low reset. It is instantiated twice, for i and j.

Test Plan:
- MEM_DEPTH=4, mem=[3,1,2,0], Start pulse -> mem=[0,1,2,3]; Busy high exactly 18 cycles; single Done pulse; Mem_Write asserted exactly 6 cycles.
- MEM_DEPTH=4, mem=[2,2,1,1] -> mem=[1,1,2,2]. On the first pass, min_addr ends at 2 (first 1), not 3.
- MEM_DEPTH=4, already sorted mem=[5,6,7,8] -> unchanged; same 18-cycle Busy; same-address double writes are harmless.
- Rst_N low at Busy cycle 7 -> all outputs 0 asynchronously, state IDLE. A fresh Start then completes a correct sort of the current memory contents.
- Start held high across the entire sort -> exactly one sort per IDLE visit. A new sort begins only on the cycle after DONE, with Busy 18 cycles again.
- SSC_PERF_CNT_EN, MEM_DEPTH=8, mem=[7,6,5,4,3,2,1,0] -> mem ascending; Sort_Cycles=56 after Done and held.
